// File: rtl/sram_controller_if.sv
// CPU-side request/response and SRAM pin bundle for sram_controller.
// master = pipeline/SRAM-model side, slave = controller.
interface sram_controller_if;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned SRAM_AW = 18;
    localparam int unsigned SRAM_DW = 16;

    logic               wr_en;
    logic               rd_en;
    logic [WORD_W-1:0]  address;
    logic [WORD_W-1:0]  wdata;
    logic [WORD_W-1:0]  rdata;
    logic               ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [SRAM_DW-1:0] sram_dq_out;
    logic               sram_dq_oe;
    logic [SRAM_DW-1:0] sram_dq_in;
    logic               sram_we_n;

    modport master (
        output wr_en, rd_en, address, wdata, sram_dq_in,
        input  rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport slave (
        input  wr_en, rd_en, address, wdata, sram_dq_in,
        output rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage access into two 16-bit SRAM phases (low then high
// halfword), freezing the pipeline via ready until the access completes.
module sram_controller #(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
    input  logic                clk,
    input  logic                rst,
    sram_controller_if.slave    bus
);
    localparam int unsigned PHASE_W = 4;
    localparam int unsigned INDEX_W = 17;
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [PHASE_W-1:0]   phase;
    logic                 op_write;
    logic                 req;
    logic                 last_phase;
    logic [INDEX_W-1:0]   word_index;

    assign req        = bus.wr_en | bus.rd_en;
    assign last_phase = (phase == LAST_PHASE);
    // Live address is used on purpose; out-of-range addresses wrap silently.
    assign word_index = INDEX_W'((bus.address - BASE_ADDR) >> 2);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and SRAM/handshake outputs
    always_comb begin
        state_next      = state;
        bus.ready       = 1'b0;
        bus.sram_addr   = '0;
        bus.sram_dq_out = '0;
        bus.sram_dq_oe  = 1'b0;
        bus.sram_we_n   = 1'b1;

        case (state)
            IDLE: begin
                bus.ready = ~req;
                if (req) begin
                    state_next = LOW;
                end
            end
            LOW: begin
                bus.sram_addr = {word_index, 1'b0};
                if (op_write) begin
                    bus.sram_dq_oe  = 1'b1;
                    bus.sram_we_n   = 1'b0;
                    bus.sram_dq_out = bus.wdata[15:0];
                end
                if (last_phase) begin
                    state_next = HIGH;
                end
            end
            HIGH: begin
                bus.sram_addr = {word_index, 1'b1};
                if (op_write) begin
                    bus.sram_dq_oe  = 1'b1;
                    bus.sram_we_n   = 1'b0;
                    bus.sram_dq_out = bus.wdata[31:16];
                end
                if (last_phase) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.ready  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Phase counter, operation latch and read-data capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase     <= '0;
            op_write  <= 1'b0;
            bus.rdata <= '0;
        end else begin
            if (state_next != state) begin
                phase <= '0;
            end else if (state == LOW || state == HIGH) begin
                phase <= phase + 1'b1;
            end

            if (state == IDLE && req) begin
                op_write <= bus.wr_en;
            end

            // Sample each halfword on the final cycle of its phase
            if (!op_write && last_phase) begin
                if (state == LOW) begin
                    bus.rdata[15:0] <= bus.sram_dq_in;
                end
                if (state == HIGH) begin
                    bus.rdata[31:16] <= bus.sram_dq_in;
                end
            end
        end
    end
endmodule
